// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader with XOR checksum
//
// Receives num_words 32-bit words as a byte stream (LSB first), writes them to
// instruction memory one word per WRITE cycle, then takes a trailing 32-bit
// checksum word.  It compares that word with the XOR of all loaded words.
// The processor is held in reset until a load finishes with a good checksum.
//
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   start, num_words      - load request and its word count (sampled on accept)
//   in_valid/in_data      - byte stream in; in_ready - byte accepted this cycle
//   mem_we/mem_addr/mem_wd- instruction memory write port (mem_addr is a word index)
//   cpu_reset             - low only once a valid image is in memory
//   busy/done/error       - status flags; words_loaded - words written so far
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  num_words,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [6:0]  words_loaded
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CKSUM = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [6:0] DEPTH_W = 7'(DEPTH);

    state_t      state_q;
    logic [6:0]  count_q;
    logic [6:0]  word_idx_q;
    logic [1:0]  byte_idx_q;
    logic [31:0] asm_q;
    logic [31:0] asm_d;
    logic [31:0] cksum_q;
    logic [6:0]  words_loaded_q;
    logic        xfer;
    logic        count_bad;

    assign in_ready = (state_q == RECV) || (state_q == CKSUM);
    assign xfer     = in_valid && in_ready;

    // num_words is 7 bits, so anything above DEPTH is caught by a plain compare
    // as long as DEPTH itself fits in 7 bits.
    assign count_bad = (num_words == 7'd0) || (num_words > DEPTH_W);

    // Assembly register with the incoming byte dropped into its lane.
    always_comb begin
        asm_d = asm_q;
        case (byte_idx_q)
            2'd0:    asm_d[7:0]   = in_data;
            2'd1:    asm_d[15:8]  = in_data;
            2'd2:    asm_d[23:16] = in_data;
            default: asm_d[31:24] = in_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            count_q        <= 7'd0;
            word_idx_q     <= 7'd0;
            byte_idx_q     <= 2'd0;
            asm_q          <= 32'd0;
            cksum_q        <= 32'd0;
            words_loaded_q <= 7'd0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        if (count_bad) begin
                            state_q <= ERROR;
                        end else begin
                            count_q        <= num_words;
                            word_idx_q     <= 7'd0;
                            byte_idx_q     <= 2'd0;
                            cksum_q        <= 32'd0;
                            words_loaded_q <= 7'd0;
                            state_q        <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (xfer) begin
                        asm_q      <= asm_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // byte_idx_q has already wrapped to 0 on the byte-3 transfer.
                    cksum_q        <= cksum_q ^ asm_q;
                    word_idx_q     <= word_idx_q + 7'd1;
                    words_loaded_q <= words_loaded_q + 7'd1;
                    if (word_idx_q == count_q - 7'd1) begin
                        state_q <= CKSUM;
                    end else begin
                        state_q <= RECV;
                    end
                end
                CKSUM: begin
                    if (xfer) begin
                        asm_q      <= asm_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            state_q <= (asm_d == cksum_q) ? DONE : ERROR;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we       = (state_q == WRITE);
    assign mem_addr     = {25'd0, word_idx_q};
    assign mem_wd       = asm_q;
    assign cpu_reset    = (state_q != DONE);
    assign busy         = (state_q == RECV) || (state_q == WRITE) || (state_q == CKSUM);
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERROR);
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  num_words;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  words_loaded;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic        prev_we = 1'b0;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(64)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    // Write monitor: every mem_we must match the next expected write and last one cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (prev_we) begin
                errors++;
                $display("FAIL mem_we_width: mem_we high on consecutive cycles, addr=%h", mem_addr);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wd);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wd} !== e) begin
                    errors++;
                    $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wd, e[63:32], e[31:0]);
                end
            end
        end
        prev_we <= mem_we;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic do_start(input logic [6:0] n);
        start = 1'b1;
        num_words = n;
        @(posedge clk);
        #1 start = 1'b0;
        num_words = 7'd5;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("byte_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = 8'hAA;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] t;
            t = w >> (8 * k);
            send_byte(t[7:0], gap);
        end
    endtask

    task automatic load_two(input logic [7:0] ck0);
        exp_q.push_back({32'd0, 32'hE3A01001});
        exp_q.push_back({32'd1, 32'hE3A020FF});
        send_word(32'hE3A01001, 1'b0);
        send_word(32'hE3A020FF, 1'b0);
        send_word({24'h000030, ck0}, 1'b0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; num_words = 7'd0; in_valid = 1'b0; in_data = 8'h00;
        @(posedge clk); #1;
        do_reset();

        // Reset state
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("rst_words_loaded", {25'd0, words_loaded}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);

        // Good 2-word load
        do_start(7'd2);
        chk("load_busy", {31'd0, busy}, 32'd1);
        chk("load_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        load_two(8'hFE);
        chk("good_done", {29'd0, busy, done, error}, 32'b010);
        chk("good_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("good_words_loaded", {25'd0, words_loaded}, 32'd2);

        // Start from DONE, bad checksum
        do_start(7'd2);
        chk("restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("restart_wl_cleared", {25'd0, words_loaded}, 32'd0);
        load_two(8'hFF);
        chk("bad_ck_flags", {29'd0, busy, done, error}, 32'b001);
        chk("bad_ck_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("bad_ck_words_loaded", {25'd0, words_loaded}, 32'd2);

        // Illegal counts
        do_reset();
        do_start(7'd0);
        chk("zero_count_error", {29'd0, busy, done, error}, 32'b001);
        do_reset();
        do_start(7'd65);
        chk("over_count_error", {29'd0, busy, done, error}, 32'b001);
        do_reset();
        do_start(7'd64);
        chk("max_count_accepted", {29'd0, busy, done, error}, 32'b100);

        // Reset mid-load after 3 bytes
        do_reset();
        do_start(7'd2);
        send_byte(8'h01, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'hA0, 1'b0);
        do_reset();
        chk("midrst_flags", {29'd0, busy, done, error}, 32'b000);
        chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("midrst_words_loaded", {25'd0, words_loaded}, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // 1-word load with in_valid toggling, must restart at address 0
        do_start(7'd1);
        exp_q.push_back({32'd0, 32'h12345678});
        send_word(32'h12345678, 1'b1);
        send_word(32'h12345678, 1'b1);
        chk("gap_done", {29'd0, busy, done, error}, 32'b010);
        chk("gap_words_loaded", {25'd0, words_loaded}, 32'd1);

        // start pulsed during RECV must be ignored
        do_start(7'd2);
        exp_q.push_back({32'd0, 32'hE3A01001});
        exp_q.push_back({32'd1, 32'hE3A020FF});
        send_byte(8'h01, 1'b0);
        do_start(7'd1);
        chk("start_ignored_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h10, 1'b0);
        send_byte(8'hA0, 1'b0);
        send_byte(8'hE3, 1'b0);
        send_word(32'hE3A020FF, 1'b0);
        send_word(32'h000030FE, 1'b0);
        chk("ignored_start_done", {29'd0, busy, done, error}, 32'b010);
        chk("ignored_start_wl", {25'd0, words_loaded}, 32'd2);

        repeat (4) @(posedge clk);
        #1;
        chk("pending_writes", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
